axis_row_producer: RTL

AXI-Stream source that emits fixed-length "rows" of BEATS_PER_ROW data beats. It is the transmit end of the row-stream link whose sink counts 66 beats per row and strobes row-complete. Software or a control FSM pulses start with a row count and an inter-row gap. The block emits a deterministic, self-checking data pattern with TLAST marking each row end, and reports per-row and end-of-job strobes.

---
 rtl/axis_row_producer_if.sv | 23 ++
 rtl/axis_row_producer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/axis_row_producer_if.sv
// AXI-Stream bus carrying row beats from the producer to its sink.
interface axis_row_producer_if #(
    parameter int unsigned DATA_WIDTH = 512
);
    logic [DATA_WIDTH-1:0] AXIS_TDATA;
    logic                  AXIS_TVALID;
    logic                  AXIS_TLAST;
    logic                  AXIS_TREADY;

    modport master (
        output AXIS_TDATA,
        output AXIS_TVALID,
        output AXIS_TLAST,
        input  AXIS_TREADY
    );

    modport slave (
        input  AXIS_TDATA,
        input  AXIS_TVALID,
        input  AXIS_TLAST,
        output AXIS_TREADY
    );
endinterface

// File: rtl/axis_row_producer.sv
// AXI-Stream row source: emits row_count rows of BEATS_PER_ROW pattern beats,
// with optional idle gaps between rows, row/job strobes and graceful abort.
module axis_row_producer #(
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned BEATS_PER_ROW = 66
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic [31:0]                row_count,
    input  logic [15:0]                gap_cycles,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       row_sent,
    axis_row_producer_if.master        axis
);
    localparam int unsigned LANES     = DATA_WIDTH / 32;
    localparam logic [15:0] LAST_BEAT = 16'(BEATS_PER_ROW - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, FINISH} state_t;

    state_t                state_q, state_d;
    logic [31:0]           rows_q, rows_d;
    logic [15:0]           gap_len_q, gap_len_d;
    logic [15:0]           gap_cnt_q, gap_cnt_d;
    logic [31:0]           row_idx_q, row_idx_d;
    logic [15:0]           beat_idx_q, beat_idx_d;
    logic                  abort_q, abort_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  row_sent_q, row_sent_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  hs;
    logic                  last_row;

    assign hs       = tvalid_q & axis.AXIS_TREADY;
    assign last_row = (row_idx_q + 32'd1) == rows_q;

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        gap_len_d  = gap_len_q;
        gap_cnt_d  = gap_cnt_q;
        row_idx_d  = row_idx_q;
        beat_idx_d = beat_idx_q;
        abort_d    = abort_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        row_sent_d = 1'b0;
        tvalid_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (row_count != '0) begin
                        rows_d     = row_count;
                        gap_len_d  = gap_cycles;
                        row_idx_d  = '0;
                        beat_idx_d = '0;
                        busy_d     = 1'b1;
                        tvalid_d   = 1'b1;
                        state_d    = SEND;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            SEND: begin
                tvalid_d = 1'b1;
                if (abort) abort_d = 1'b1;
                if (hs) begin
                    if (beat_idx_q == LAST_BEAT) begin
                        row_sent_d = 1'b1;
                        beat_idx_d = '0;
                        row_idx_d  = row_idx_q + 32'd1;
                        // Abort arriving with the TLAST handshake counts as already latched.
                        if (last_row || abort_q || abort) begin
                            tvalid_d = 1'b0;
                            done_d   = 1'b1;
                            busy_d   = 1'b0;
                            state_d  = FINISH;
                        end else if (gap_len_q != '0) begin
                            tvalid_d  = 1'b0;
                            gap_cnt_d = gap_len_q;
                            state_d   = GAP;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + 16'd1;
                    end
                end
            end
            GAP: begin
                if (abort || abort_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FINISH;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                    if (gap_cnt_q == 16'd1) begin
                        tvalid_d = 1'b1;
                        state_d  = SEND;
                    end
                end
            end
            FINISH: begin
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        tlast_d = tvalid_d && (beat_idx_d == LAST_BEAT);
        tdata_d = {LANES{row_idx_d[15:0], beat_idx_d}};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            rows_q     <= '0;
            gap_len_q  <= '0;
            gap_cnt_q  <= '0;
            row_idx_q  <= '0;
            beat_idx_q <= '0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            row_sent_q <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            gap_len_q  <= gap_len_d;
            gap_cnt_q  <= gap_cnt_d;
            row_idx_q  <= row_idx_d;
            beat_idx_q <= beat_idx_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            row_sent_q <= row_sent_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign row_sent         = row_sent_q;
    assign axis.AXIS_TDATA  = tdata_q;
    assign axis.AXIS_TVALID = tvalid_q;
    assign axis.AXIS_TLAST  = tlast_q;
endmodule
